regfile_wb_arbiter: RTL and testbench

- Write-back controller in front of the 16x16 register file's single write port (C / Caddr / Load).
- Arbitrates two write-back requesters (0 = ALU, 1 = memory/load unit) onto that port using round-robin with valid/ready handshakes.
- Keeps a 16-entry busy scoreboard of registers with pending writes. Issue logic uses it for RAW and WAW hazard detection.

---
 rtl/regfile_wb_arbiter.sv | 116 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Write-back controller for the register file's single write port: round-robin
// arbitration of two requesters, one registered write stage, and a busy scoreboard.
module regfile_wb_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int NREG   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rsv_valid,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              rsv_ready,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] chk_a_addr,
    input  logic [ADDR_W-1:0] chk_b_addr,
    output logic              hazard_a,
    output logic              hazard_b,
    output logic              wb_load,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic [NREG-1:0]   busy_vec
);

    logic              prio;
    logic              gnt0;
    logic              gnt1;
    logic              vld_p0;
    logic [ADDR_W-1:0] addr_p0;
    logic [DATA_W-1:0] data_p0;
    logic              vld_p1;
    logic [ADDR_W-1:0] addr_p1;
    logic [DATA_W-1:0] data_p1;
    logic [NREG-1:0]   busy;
    logic [NREG-1:0]   busy_set;
    logic [NREG-1:0]   busy_clr;
    logic [NREG-1:0]   busy_next;

    // Returns {gnt1, gnt0}; prio only matters when both requesters are valid.
    function automatic logic [1:0] rr_grant(input logic v0, input logic v1, input logic p);
        if (v0 && v1)
            return p ? 2'b10 : 2'b01;
        return {v1, v0};
    endfunction

    function automatic logic [NREG-1:0] onehot(input logic [ADDR_W-1:0] a);
        logic [NREG-1:0] v;
        v    = '0;
        v[a] = 1'b1;
        return v;
    endfunction

    // Stage p0: combinational arbitration and winner mux
    always_comb begin
        {gnt1, gnt0} = rr_grant(req0_valid, req1_valid, prio);
        vld_p0       = gnt0 | gnt1;
        addr_p0      = gnt1 ? req1_addr : req0_addr;
        data_p0      = gnt1 ? req1_data : req0_data;
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            prio <= 1'b0;
        else if (vld_p0)
            prio <= gnt0;
    end

    // Stage p1: registered write port toward the register file
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            addr_p1 <= '0;
            data_p1 <= '0;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                addr_p1 <= addr_p0;
                data_p1 <= data_p0;
            end
        end
    end

    assign wb_load = vld_p1;
    assign wb_addr = addr_p1;
    assign wb_data = data_p1;

    // A reservation may re-claim a register whose write lands on this very edge.
    assign rsv_ready = !busy[rsv_addr] || (vld_p1 && (addr_p1 == rsv_addr));

    always_comb begin
        busy_set  = (rsv_valid && rsv_ready) ? onehot(rsv_addr) : '0;
        busy_clr  = vld_p1 ? onehot(addr_p1) : '0;
        busy_next = (busy & ~busy_clr) | busy_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            busy <= '0;
        else
            busy <= busy_next;
    end

    assign busy_vec = busy;
    assign hazard_a = busy[chk_a_addr];
    assign hazard_b = busy[chk_b_addr];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: directed stimulus pushes expected
// write-backs, a negedge monitor pops them whenever wb_load is seen.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rsv_valid = 1'b0;
    logic [3:0]  rsv_addr = '0;
    logic        rsv_ready;
    logic        req0_valid = 1'b0;
    logic [3:0]  req0_addr = '0;
    logic [15:0] req0_data = '0;
    logic        req0_ready;
    logic        req1_valid = 1'b0;
    logic [3:0]  req1_addr = '0;
    logic [15:0] req1_data = '0;
    logic        req1_ready;
    logic [3:0]  chk_a_addr = '0;
    logic [3:0]  chk_b_addr = '0;
    logic        hazard_a;
    logic        hazard_b;
    logic        wb_load;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic [15:0] busy_vec;

    regfile_wb_arbiter #(.DATA_W(16), .ADDR_W(4), .NREG(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ready(rsv_ready),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .chk_a_addr(chk_a_addr), .chk_b_addr(chk_b_addr),
        .hazard_a(hazard_a), .hazard_b(hazard_b),
        .wb_load(wb_load), .wb_addr(wb_addr), .wb_data(wb_data), .busy_vec(busy_vec)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  a;
        logic [15:0] d;
    } wb_t;

    wb_t         exp_q[$];
    wb_t         mon_e;
    int          errors = 0;
    int          checks = 0;
    logic [15:0] rf [16];
    int          rf_writes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] a, input logic [15:0] d);
        exp_q.push_back('{a: a, d: d});
    endtask

    // Register-file model: captures on the edge where wb_load is high.
    always @(posedge clk) begin
        if (wb_load) begin
            rf[wb_addr] <= wb_data;
            rf_writes   <= rf_writes + 1;
        end
    end

    always @(negedge clk) begin
        if (rst_n && wb_load) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wb_unexpected: got addr=0x%0h data=0x%0h required no write", wb_addr, wb_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("wb_addr", {28'd0, wb_addr}, {28'd0, mon_e.a});
                check("wb_data", {16'd0, wb_data}, {16'd0, mon_e.d});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wcount;

        // Reset state
        step();
        check("rst_wb_load", {31'd0, wb_load}, 32'd0);
        check("rst_wb_addr", {28'd0, wb_addr}, 32'd0);
        check("rst_wb_data", {16'd0, wb_data}, 32'd0);
        check("rst_busy", {16'd0, busy_vec}, 32'd0);
        rst_n = 1'b1;

        // Single request from requester 0
        req0_valid = 1'b1; req0_addr = 4'd3; req0_data = 16'h1234;
        #1;
        check("t1_req0_ready", {31'd0, req0_ready}, 32'd1);
        check("t1_req1_ready", {31'd0, req1_ready}, 32'd0);
        push(4'd3, 16'h1234);
        step();
        req0_valid = 1'b0;
        check("t1_load_hi", {31'd0, wb_load}, 32'd1);
        step();
        check("t1_load_lo", {31'd0, wb_load}, 32'd0);
        check("t1_addr_hold", {28'd0, wb_addr}, 32'd3);
        check("t1_data_hold", {16'd0, wb_data}, 32'h1234);

        // Fresh reset so prio=0, then both requesters held valid
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        req0_valid = 1'b1; req0_addr = 4'd1; req0_data = 16'hAAAA;
        req1_valid = 1'b1; req1_addr = 4'd2; req1_data = 16'hBBBB;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("t2_req0_ready", {31'd0, req0_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
            check("t2_req1_ready", {31'd0, req1_ready}, (k % 2 == 1) ? 32'd1 : 32'd0);
            if (k % 2 == 0) push(4'd1, 16'hAAAA);
            else            push(4'd2, 16'hBBBB);
            step();
            check("t2_load_hi", {31'd0, wb_load}, 32'd1);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();

        // Reservation, duplicate reservation, write clears busy
        rsv_valid = 1'b1; rsv_addr = 4'd5; chk_a_addr = 4'd5; chk_b_addr = 4'd6;
        #1;
        check("t3_rsv_ready", {31'd0, rsv_ready}, 32'd1);
        check("t3_hz_a_pre", {31'd0, hazard_a}, 32'd0);
        step();
        rsv_valid = 1'b0;
        #1;
        check("t3_busy", {16'd0, busy_vec}, 32'h0020);
        check("t3_hz_a", {31'd0, hazard_a}, 32'd1);
        check("t3_hz_b", {31'd0, hazard_b}, 32'd0);
        rsv_valid = 1'b1;
        #1;
        check("t3_rsv_dup", {31'd0, rsv_ready}, 32'd0);
        rsv_valid = 1'b0;
        req1_valid = 1'b1; req1_addr = 4'd5; req1_data = 16'h5555;
        #1;
        check("t3_req1_ready", {31'd0, req1_ready}, 32'd1);
        push(4'd5, 16'h5555);
        step();
        req1_valid = 1'b0;
        #1;
        check("t3_wb_load", {31'd0, wb_load}, 32'd1);
        check("t3_hz_during", {31'd0, hazard_a}, 32'd1);
        check("t3_busy_during", {16'd0, busy_vec}, 32'h0020);
        step();
        check("t3_busy_clr", {16'd0, busy_vec}, 32'h0000);
        check("t3_hz_after", {31'd0, hazard_a}, 32'd0);

        // Reservation on the same edge as the clearing write: set wins
        rsv_valid = 1'b1; rsv_addr = 4'd5;
        step();
        rsv_valid = 1'b0;
        req0_valid = 1'b1; req0_addr = 4'd5; req0_data = 16'h6666;
        #1;
        check("t4_req0_ready", {31'd0, req0_ready}, 32'd1);
        push(4'd5, 16'h6666);
        step();
        req0_valid = 1'b0;
        rsv_valid = 1'b1; rsv_addr = 4'd5;
        #1;
        check("t4_wb_addr5", {27'd0, wb_load, wb_addr}, 32'h15);
        check("t4_rsv_ready", {31'd0, rsv_ready}, 32'd1);
        step();
        rsv_valid = 1'b0;
        #1;
        check("t4_busy_kept", {16'd0, busy_vec}, 32'h0020);
        req0_valid = 1'b1; req0_data = 16'h7777;
        push(4'd5, 16'h7777);
        step();
        req0_valid = 1'b0;
        step();
        check("t4_busy_clr", {16'd0, busy_vec}, 32'h0000);

        // Same address from both with prio=1 (last transfer was requester 0)
        req0_valid = 1'b1; req0_addr = 4'd7; req0_data = 16'h0001;
        req1_valid = 1'b1; req1_addr = 4'd7; req1_data = 16'h0002;
        #1;
        check("t5_req1_first", {30'd0, req1_ready, req0_ready}, 32'b10);
        push(4'd7, 16'h0002);
        step();
        req1_valid = 1'b0;
        #1;
        check("t5_req0_second", {30'd0, req1_ready, req0_ready}, 32'b01);
        push(4'd7, 16'h0001);
        step();
        req0_valid = 1'b0;
        step();
        check("t5_r7", {16'd0, rf[7]}, 32'h0001);

        // Asynchronous reset while a write-back is pending
        for (int i = 0; i < 8; i++) begin
            rsv_valid = 1'b1; rsv_addr = 4'(i);
            step();
        end
        rsv_valid = 1'b0;
        req0_valid = 1'b1; req0_addr = 4'd0; req0_data = 16'hDEAD;
        step();
        req0_valid = 1'b0;
        #1;
        check("t6_pre_load", {31'd0, wb_load}, 32'd1);
        check("t6_pre_busy", {16'd0, busy_vec}, 32'h00FF);
        wcount = rf_writes;
        rst_n = 1'b0;
        #1;
        check("t6_rst_load", {31'd0, wb_load}, 32'd0);
        check("t6_rst_busy", {16'd0, busy_vec}, 32'd0);
        step();
        check("t6_no_write", rf_writes, wcount);
        rst_n = 1'b1;
        step();
        step();

        check("sb_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
